// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, register-zero constant and writeback entry type
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// rtl/wb_load_fifo.sv - circular queue of pending load results {dst, data}
//
// Ports:
//   CLK, reset        clock (rising edge), asynchronous active-low reset
//   push, push_entry  write one entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   head              entry at the read pointer, valid when !empty
//   full, empty       functions of the registered pointers only
module wb_load_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      CLK,
    input  logic      reset,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    // Pointers carry one extra MSB: equal low bits with differing MSBs means
    // the writer has lapped the reader, i.e. the queue is full.
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register-file write port with load queue, ALU priority and pending-write scoreboard
//
// Optional feature: define WB_BYPASS_EN to add same-cycle forwarding of the
// committing result (rs_fwd/rt_fwd, fwd_data_rs/fwd_data_rt).
//
// Ports:
//   CLK, reset                      clock, asynchronous active-low reset
//   iss_valid, iss_dst              decode issues an instruction writing iss_dst
//   rs_addr, rt_addr                decode source registers
//   rs_busy, rt_busy, waw_stall     hazard flags from the pending scoreboard
//   alu_valid, alu_dst, alu_data    single-cycle ALU result, never stalled
//   mem_valid, mem_ready            load result handshake into the queue
//   mem_dst, mem_data               load result
//   wr_en, wr_addr, wr_data         registered register-file write
//   err_waw                         sticky flag: issue to an already-pending register
//   rs_fwd, rt_fwd, fwd_data_rs/rt  (WB_BYPASS_EN) forwarding of the committing result
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int MEMQ_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              waw_stall,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
`ifdef WB_BYPASS_EN
    output logic              rs_fwd,
    output logic              rt_fwd,
    output logic [DATA_W-1:0] fwd_data_rs,
    output logic [DATA_W-1:0] fwd_data_rt,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              err_waw
);

    localparam int NREGS = 2 ** ADDR_W;

    wb_entry_t  mem_entry;
    wb_entry_t  head_entry;
    wb_entry_t  sel_entry;
    logic       q_full;
    logic       q_empty;
    logic       q_push;
    logic       q_pop;
    logic       sel_valid;
    logic       commit_we;

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic             rs_pend;
    logic             rt_pend;

    assign mem_entry = '{dst: mem_dst, data: mem_data};

    // mem_ready depends on registered pointers only; a pop this cycle does not
    // open a slot until the next one, which keeps mem_ready off the ALU path.
    assign mem_ready = !q_full;
    assign q_push    = mem_valid && mem_ready;

    wb_load_fifo #(
        .DEPTH (MEMQ_DEPTH)
    ) u_load_fifo (
        .CLK        (CLK),
        .reset      (reset),
        .push       (q_push),
        .push_entry (mem_entry),
        .pop        (q_pop),
        .head       (head_entry),
        .full       (q_full),
        .empty      (q_empty)
    );

    // ALU results cannot wait, so they always win; the queue drains in bubbles.
    always_comb begin
        sel_valid = 1'b0;
        q_pop     = 1'b0;
        sel_entry = head_entry;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_entry = '{dst: alu_dst, data: alu_data};
        end else if (!q_empty) begin
            sel_valid = 1'b1;
            q_pop     = 1'b1;
        end
    end

    // A commit to r0 still consumes its slot but never reaches the register file.
    assign commit_we = sel_valid && (sel_entry.dst != REG_ZERO);

    // Clear first, then set, so an issue to a register committing this same
    // cycle leaves the newer write pending.
    always_comb begin
        pending_nxt = pending;
        if (sel_valid) begin
            pending_nxt[sel_entry.dst] = 1'b0;
        end
        if (iss_valid && (iss_dst != REG_ZERO)) begin
            pending_nxt[iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            pending <= '0;
            err_waw <= 1'b0;
        end else begin
            wr_en   <= commit_we;
            if (commit_we) begin
                wr_addr <= sel_entry.dst;
                wr_data <= sel_entry.data;
            end
            pending <= pending_nxt;
            if (iss_valid && waw_stall) begin
                err_waw <= 1'b1;
            end
        end
    end

    assign rs_pend   = (rs_addr != REG_ZERO) && pending[rs_addr];
    assign rt_pend   = (rt_addr != REG_ZERO) && pending[rt_addr];
    assign waw_stall = pending[iss_dst];

`ifdef WB_BYPASS_EN
    // The result being selected now is the value decode would have waited for,
    // so hand it over directly and drop the stall in the same cycle.
    assign rs_fwd      = commit_we && (sel_entry.dst == rs_addr);
    assign rt_fwd      = commit_we && (sel_entry.dst == rt_addr);
    assign fwd_data_rs = sel_entry.data;
    assign fwd_data_rt = sel_entry.data;
    assign rs_busy     = rs_pend && !rs_fwd;
    assign rt_busy     = rt_pend && !rt_fwd;
`else
    assign rs_busy     = rs_pend;
    assign rt_busy     = rt_pend;
`endif

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Initiator side of the register-file write port.
- Collects results from the single-cycle ALU path and from the variable-latency load path, buffers loads in a small queue and arbitrates between the two sources.
- Drives one registered write per cycle into the register file.
- Keeps a 32-entry pending-write scoreboard so decode can stall RAW/WAW hazards on registers whose results are still in flight.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width; the scoreboard has 2**ADDR_W bits.
- MEMQ_DEPTH, 2, load-result queue entries; must be a power of two and at least 2.

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iss_valid  in  1  decode issues an instruction with a destination register.
- iss_dst  in  ADDR_W  destination register of the issued instruction.
- rs_addr  in  ADDR_W  source register A of the instruction in decode.
- rt_addr  in  ADDR_W  source register B of the instruction in decode.
- rs_busy  out  1  rs_addr has a pending write.
- rt_busy  out  1  rt_addr has a pending write.
- waw_stall  out  1  iss_dst has a pending write.
- alu_valid  in  1  ALU result present this cycle; cannot be back-pressured.
- alu_dst  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  load queue can accept a result.
- mem_dst  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- wr_en  out  1  register-file write enable.
- wr_addr  out  ADDR_W  register-file write address.
- wr_data  out  DATA_W  register-file write data.
- err_waw  out  1  sticky: issue was made to an already-pending register.

Behaviour:
- Reset (reset low, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0.
  - Scoreboard cleared; queue empty; mem_ready=1; err_waw=0.
  - Reset mid-operation discards queued loads and pending bits.
- Load queue:
  - Circular FIFO of {dst, data}.
  - Push when mem_valid && mem_ready.
  - mem_ready = !full, a registered-state function only. A pop does not free a slot in the same cycle.
- Arbitration each cycle:
  - alu_valid wins.
  - Otherwise, if the queue is non-empty, the head is popped and committed.
  - Only one commit per cycle. The load path may starve while the ALU streams; the pipeline guarantees bubbles.
- Commit timing:
  - The selected {dst, data} is registered onto wr_addr/wr_data with wr_en=1 on the next rising edge. Latency is 1 cycle from alu_valid or queue-head selection.
  - wr_en pulses exactly one cycle per commit.
  - wr_en is asserted regardless of data value; zero data is written like any other value.
- Register 0:
  - A commit with dst=0 consumes its slot (queue pops, ALU accepted) but produces wr_en=0.
  - iss_dst=0 never sets a pending bit.
  - rs_busy/rt_busy are always 0 for address 0.
- Scoreboard:
  - iss_valid sets pending[iss_dst].
  - A commit clears pending[dst] in the cycle it is selected, i.e. the same edge that raises wr_en.
  - Set and clear of the same register in one cycle: set wins.
- Hazard outputs:
  - rs_busy = pending[rs_addr]; rt_busy = pending[rt_addr]; waw_stall = pending[iss_dst]. All combinational from registered state.
  - iss_valid while waw_stall=1 sets err_waw until reset; the pending bit stays set.
- Wrap-around: queue pointers carry an extra MSB to distinguish full from empty.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Adds outputs rs_fwd, rt_fwd (1 bit) and fwd_data_rs, fwd_data_rt (DATA_W).
  - When a commit to a nonzero dst is being selected this cycle and matches rs_addr/rt_addr, the matching busy output is forced 0, the fwd flag is 1, and the fwd data equals the committing data. This is combinational, the same cycle as selection.
- Undefined:
  - Ports absent.
  - busy stays 1 until the cycle after commit selection.

Decomposition:
- Shared package (cpu_pkg) holds DATA_W, ADDR_W, REG_ZERO=0 and the writeback-entry typedef {dst, data}.
- One natural sub-module: wb_load_fifo (the parameterised queue with full/empty).
- Arbitration and scoreboard stay in writeback_unit.

Test Plan:
- Reset sequence: drive reset low mid-stream with 2 queued loads -> wr_en=0, mem_ready=1, all busy=0 immediately; no writes after release.
- ALU write and scoreboard: iss_valid dst=5, later alu_valid dst=5 data=0xDEADBEEF -> rs_busy(rs=5) high until commit; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; rs_busy=0 afterwards.
- ALU priority over loads: alu_valid for 3 consecutive cycles while loads dst=7 and dst=8 arrive -> queue fills, mem_ready=0; ALU writes appear first, then dst=7 and dst=8 in order; mem_ready returns to 1 one cycle after the first pop.
- Register zero: alu_valid dst=0 data=0x1 -> no wr_en; iss dst=0 -> waw_stall never asserts.
- WAW error: iss dst=3 twice without commit -> waw_stall=1 on the second issue, err_waw sticks at 1 until reset.
- Bypass (WB_BYPASS_EN): rs_addr=9 with an ALU commit to 9 data=0x1234 this cycle -> rs_busy=0, rs_fwd=1, fwd_data_rs=0x1234.
